// File: rtl/ai_sa_aw_arbiter_if.sv
// AW request bundle between the dispatchers, the slave AW port and the W-order consumer.
// The master modport is the arbiter's view; the slave modport is the surrounding environment's view.
interface ai_sa_aw_arbiter_if #(
    parameter int unsigned MST_AMT           = 3,
    parameter int unsigned MST_ID_W          = $clog2(MST_AMT),
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned TRANS_MST_ID_W    = 5,
    parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
    parameter int unsigned TRANS_DATA_LEN_W  = 3,
    parameter int unsigned TRANS_DATA_SIZE_W = 3
);
    logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AWID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AWADDR_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AWLEN_i;
    logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AWSIZE_i;
    logic [MST_AMT-1:0]                   dsp_AWVALID_i;
    logic [MST_AMT-1:0]                   dsp_AWREADY_o;

    logic [TRANS_SLV_ID_W-1:0]            s_AWID_o;
    logic [ADDR_WIDTH-1:0]                s_AWADDR_o;
    logic [TRANS_DATA_LEN_W-1:0]          s_AWLEN_o;
    logic [TRANS_DATA_SIZE_W-1:0]         s_AWSIZE_o;
    logic                                 s_AWVALID_o;
    logic                                 s_AWREADY_i;

    logic [MST_ID_W-1:0]                  wo_mst_id_o;
    logic                                 wo_valid_o;
    logic                                 wo_ready_i;

    modport master (
        input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWSIZE_i, dsp_AWVALID_i,
        output dsp_AWREADY_o,
        output s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        input  s_AWREADY_i,
        output wo_mst_id_o, wo_valid_o,
        input  wo_ready_i
    );

    modport slave (
        output dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWSIZE_i, dsp_AWVALID_i,
        input  dsp_AWREADY_o,
        input  s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        output s_AWREADY_i,
        input  wo_mst_id_o, wo_valid_o,
        output wo_ready_i
    );
endinterface

// File: rtl/ai_sa_aw_arbiter.sv
// Write-address arbiter for one slave: weighted round-robin over MST_AMT dispatchers,
// registered AW toward the slave, and a W-order FIFO recording the grant sequence.
module ai_sa_aw_arbiter #(
    parameter int unsigned MST_AMT                  = 3,
    parameter logic [32*MST_AMT-1:0] MST_WEIGHT     = {32'd5, 32'd3, 32'd2},
    parameter int unsigned MST_ID_W                 = $clog2(MST_AMT),
    parameter int unsigned OUTSTANDING_AMT          = 8,
    parameter int unsigned ADDR_WIDTH               = 32,
    parameter int unsigned TRANS_MST_ID_W           = 5,
    parameter int unsigned TRANS_SLV_ID_W           = TRANS_MST_ID_W + MST_ID_W,
    parameter int unsigned TRANS_DATA_LEN_W         = 3,
    parameter int unsigned TRANS_DATA_SIZE_W        = 3
) (
    input  logic                ACLK_i,
    input  logic                ARESET_i,
    ai_sa_aw_arbiter_if.master  aw_if
);
    localparam int unsigned PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Weight words are stored master 0 first (MSB); a zero weight behaves as one.
    function automatic logic [31:0] weight_of(input logic [MST_ID_W-1:0] idx);
        int unsigned i;
        logic [31:0] w;
        i = 32'(idx);
        w = MST_WEIGHT[32*(MST_AMT-1-i) +: 32];
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

    function automatic logic [MST_ID_W-1:0] next_idx(input logic [MST_ID_W-1:0] idx);
        return (32'(idx) == MST_AMT - 1) ? '0 : idx + MST_ID_W'(1);
    endfunction

    logic [MST_ID_W-1:0]          ptr_q, ptr_d;
    logic [31:0]                  credit_q, credit_d;
    logic [31:0]                  cred_tmp;

    logic                         s_valid_q;
    logic [TRANS_SLV_ID_W-1:0]    s_id_q;
    logic [ADDR_WIDTH-1:0]        s_addr_q;
    logic [TRANS_DATA_LEN_W-1:0]  s_len_q;
    logic [TRANS_DATA_SIZE_W-1:0] s_size_q;

    logic [MST_ID_W-1:0]          mem_q [OUTSTANDING_AMT];
    logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]             count_q, count_d;

    logic                         grant_vld;
    logic [MST_ID_W-1:0]          grant_idx;
    logic [MST_ID_W-1:0]          cand_idx;
    int unsigned                  cand;
    logic                         can_accept, accept, push, pop;
    logic [MST_AMT-1:0]           ready_vec;

    logic [TRANS_MST_ID_W-1:0]    sel_id;
    logic [ADDR_WIDTH-1:0]        sel_addr;
    logic [TRANS_DATA_LEN_W-1:0]  sel_len;
    logic [TRANS_DATA_SIZE_W-1:0] sel_size;

    // Search starts at ptr so the master holding credit keeps priority.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < MST_AMT; k++) begin
            cand     = (32'(ptr_q) + k) % MST_AMT;
            cand_idx = cand[MST_ID_W-1:0];
            if (!grant_vld && aw_if.dsp_AWVALID_i[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        sel_id   = aw_if.dsp_AWID_i[TRANS_MST_ID_W*(MST_AMT-1-32'(grant_idx)) +: TRANS_MST_ID_W];
        sel_addr = aw_if.dsp_AWADDR_i[ADDR_WIDTH*(MST_AMT-1-32'(grant_idx)) +: ADDR_WIDTH];
        sel_len  = aw_if.dsp_AWLEN_i[TRANS_DATA_LEN_W*(MST_AMT-1-32'(grant_idx)) +: TRANS_DATA_LEN_W];
        sel_size = aw_if.dsp_AWSIZE_i[TRANS_DATA_SIZE_W*(MST_AMT-1-32'(grant_idx)) +: TRANS_DATA_SIZE_W];
    end

    // Full is judged on the current count, so a same-cycle pop never frees a slot early.
    always_comb begin
        can_accept = (!s_valid_q || aw_if.s_AWREADY_i) && (count_q != CNT_W'(OUTSTANDING_AMT));
        accept     = can_accept && grant_vld;
        ready_vec  = '0;
        if (accept) begin
            ready_vec[grant_idx] = 1'b1;
        end
        push = accept;
        pop  = (count_q != '0) && aw_if.wo_ready_i;
    end

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        cred_tmp = '0;
        if (accept) begin
            cred_tmp = (grant_idx == ptr_q) ? credit_q - 32'd1 : weight_of(grant_idx) - 32'd1;
            if (cred_tmp == 32'd0) begin
                ptr_d    = next_idx(grant_idx);
                credit_d = weight_of(next_idx(grant_idx));
            end else begin
                ptr_d    = grant_idx;
                credit_d = cred_tmp;
            end
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            ptr_q     <= '0;
            credit_q  <= weight_of(MST_ID_W'(0));
            s_valid_q <= 1'b0;
            s_id_q    <= '0;
            s_addr_q  <= '0;
            s_len_q   <= '0;
            s_size_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < OUTSTANDING_AMT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            if (accept) begin
                s_valid_q <= 1'b1;
                s_id_q    <= {grant_idx, sel_id};
                s_addr_q  <= sel_addr;
                s_len_q   <= sel_len;
                s_size_q  <= sel_size;
            end else if (aw_if.s_AWREADY_i) begin
                s_valid_q <= 1'b0;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign aw_if.dsp_AWREADY_o = ready_vec;
    assign aw_if.s_AWID_o      = s_id_q;
    assign aw_if.s_AWADDR_o    = s_addr_q;
    assign aw_if.s_AWLEN_o     = s_len_q;
    assign aw_if.s_AWSIZE_o    = s_size_q;
    assign aw_if.s_AWVALID_o   = s_valid_q;
    assign aw_if.wo_mst_id_o   = mem_q[rd_ptr_q];
    assign aw_if.wo_valid_o    = (count_q != '0);

endmodule

// File: tb/tb_ai_sa_aw_arbiter.sv
// Directed bench for ai_sa_aw_arbiter: per-cycle vectors with hand-computed grants,
// expected slave AW register and W-order FIFO contents tracked from those grants.
module tb_ai_sa_aw_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ai_sa_aw_arbiter_if #(
        .MST_AMT(3), .MST_ID_W(2), .ADDR_WIDTH(32), .TRANS_MST_ID_W(5),
        .TRANS_SLV_ID_W(7), .TRANS_DATA_LEN_W(3), .TRANS_DATA_SIZE_W(3)
    ) bus ();

    ai_sa_aw_arbiter #(
        .MST_AMT(3), .MST_WEIGHT({32'd5, 32'd3, 32'd2}), .OUTSTANDING_AMT(8),
        .ADDR_WIDTH(32), .TRANS_MST_ID_W(5), .TRANS_DATA_LEN_W(3), .TRANS_DATA_SIZE_W(3)
    ) dut (
        .ACLK_i   (clk),
        .ARESET_i (rst),
        .aw_if    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] vld;
        logic       srdy;
        logic       wrdy;
        logic [2:0] exp_rdy;
    } vec_t;

    vec_t        tbl[$];
    int          checks   = 0;
    int          failures = 0;

    logic [4:0]  m_id   [3];
    logic [31:0] m_addr [3];
    logic [2:0]  m_len  [3];
    logic [2:0]  m_size [3];

    logic        exp_sv;
    logic [6:0]  exp_id;
    logic [31:0] exp_addr;
    logic [2:0]  exp_len;
    logic [2:0]  exp_size;
    logic [1:0]  woq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_sv = 1'b0; exp_id = '0; exp_addr = '0; exp_len = '0; exp_size = '0;
        woq.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " s_valid"}, 64'(bus.s_AWVALID_o), 64'(exp_sv));
        chk({tag, " s_id"},    64'(bus.s_AWID_o),    64'(exp_id));
        chk({tag, " s_addr"},  64'(bus.s_AWADDR_o),  64'(exp_addr));
        chk({tag, " s_len"},   64'(bus.s_AWLEN_o),   64'(exp_len));
        chk({tag, " s_size"},  64'(bus.s_AWSIZE_o),  64'(exp_size));
        chk({tag, " wo_valid"}, 64'(bus.wo_valid_o), 64'(woq.size() != 0));
        if (woq.size() != 0) chk({tag, " wo_id"}, 64'(bus.wo_mst_id_o), 64'(woq[0]));
    endtask

    task automatic do_reset(input logic [2:0] vld, input string tag);
        @(negedge clk);
        rst = 1'b1;
        bus.dsp_AWVALID_i = vld;
        bus.s_AWREADY_i   = 1'b1;
        bus.wo_ready_i    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.dsp_AWVALID_i = '0;
        #1;
        clear_model();
        chk({tag, " ready"}, 64'(bus.dsp_AWREADY_o), 64'd0);
        check_outputs(tag);
    endtask

    task automatic step(input logic [2:0] vld, input logic srdy, input logic wrdy,
                        input logic [2:0] exp_rdy, input string tag);
        logic [1:0] g;
        @(negedge clk);
        bus.dsp_AWVALID_i = vld;
        bus.s_AWREADY_i   = srdy;
        bus.wo_ready_i    = wrdy;
        #1;
        chk({tag, " ready"}, 64'(bus.dsp_AWREADY_o), 64'(exp_rdy));
        check_outputs(tag);
        g = exp_rdy[2] ? 2'd2 : (exp_rdy[1] ? 2'd1 : 2'd0);
        if (exp_rdy != 3'b000) begin
            exp_sv = 1'b1; exp_id = {g, m_id[g]};
            exp_addr = m_addr[g]; exp_len = m_len[g]; exp_size = m_size[g];
        end else if (srdy) begin
            exp_sv = 1'b0;
        end
        if (woq.size() != 0 && wrdy) void'(woq.pop_front());
        if (exp_rdy != 3'b000) woq.push_back(g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_id[0] = 5'h03; m_addr[0] = 32'h4000_0000; m_len[0] = 3'd3; m_size[0] = 3'd2;
        m_id[1] = 5'h11; m_addr[1] = 32'h5000_0010; m_len[1] = 3'd1; m_size[1] = 3'd1;
        m_id[2] = 5'h1A; m_addr[2] = 32'h6000_0020; m_len[2] = 3'd7; m_size[2] = 3'd3;
        bus.dsp_AWID_i    = {m_id[0], m_id[1], m_id[2]};
        bus.dsp_AWADDR_i  = {m_addr[0], m_addr[1], m_addr[2]};
        bus.dsp_AWLEN_i   = {m_len[0], m_len[1], m_len[2]};
        bus.dsp_AWSIZE_i  = {m_size[0], m_size[1], m_size[2]};
        bus.dsp_AWVALID_i = '0;
        bus.s_AWREADY_i   = 1'b0;
        bus.wo_ready_i    = 1'b0;
        clear_model();

        // WRR fairness, weights 5/3/2: 0 x5, 1 x3, 2 x2, twice round
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 3'b000});
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                tbl.push_back('{1'b0, 3'b111, 1'b1, 1'b1,
                                (i < 5) ? 3'b001 : ((i < 8) ? 3'b010 : 3'b100)});
            end
        end
        tbl.push_back('{1'b0, 3'b000, 1'b1, 1'b1, 3'b000});
        // Drop mid-quota: master 1 x2, drops, master 2 full quota 2, master 1 back x3
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 3'b000});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b010});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b010});
        tbl.push_back('{1'b0, 3'b100, 1'b1, 1'b1, 3'b100});
        tbl.push_back('{1'b0, 3'b100, 1'b1, 1'b1, 3'b100});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b010});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b010});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b010});
        tbl.push_back('{1'b0, 3'b110, 1'b1, 1'b1, 3'b100});
        tbl.push_back('{1'b0, 3'b000, 1'b1, 1'b1, 3'b000});

        do_reset(3'b000, "reset");

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) do_reset(3'b000, $sformatf("vec%0d rst", n));
            else step(tbl[n].vld, tbl[n].srdy, tbl[n].wrdy, tbl[n].exp_rdy, $sformatf("vec%0d", n));
        end

        // Single stream from master 0, then drain the four FIFO entries
        do_reset(3'b000, "single rst");
        for (int i = 0; i < 4; i++) step(3'b001, 1'b1, 1'b0, 3'b001, "single");
        step(3'b000, 1'b1, 1'b0, 3'b000, "single tail");
        for (int i = 0; i < 5; i++) step(3'b000, 1'b1, 1'b1, 3'b000, "single drain");

        // Slave backpressure: payload frozen, no further grants until released
        do_reset(3'b000, "bp rst");
        step(3'b111, 1'b0, 1'b1, 3'b001, "bp first");
        for (int i = 0; i < 4; i++) step(3'b111, 1'b0, 1'b1, 3'b000, "bp stall");
        step(3'b111, 1'b1, 1'b1, 3'b001, "bp release");
        step(3'b000, 1'b1, 1'b1, 3'b000, "bp present");
        step(3'b000, 1'b1, 1'b1, 3'b000, "bp idle");

        // FIFO full: 8 accepts, a pop while full does not unblock that cycle
        do_reset(3'b000, "full rst");
        for (int i = 0; i < 8; i++) step(3'b100, 1'b1, 1'b0, 3'b100, "full fill");
        step(3'b100, 1'b1, 1'b0, 3'b000, "full block");
        step(3'b100, 1'b1, 1'b1, 3'b000, "full pop");
        step(3'b100, 1'b1, 1'b0, 3'b100, "full refill");
        step(3'b100, 1'b1, 1'b0, 3'b000, "full again");
        for (int i = 0; i < 9; i++) step(3'b000, 1'b1, 1'b1, 3'b000, "full drain");

        // Reset mid-burst with s_AWVALID high and five FIFO entries
        do_reset(3'b000, "mid rst0");
        for (int i = 0; i < 5; i++) step(3'b001, 1'b1, 1'b0, 3'b001, "mid fill");
        do_reset(3'b111, "mid rst");
        step(3'b111, 1'b1, 1'b0, 3'b001, "mid first");
        step(3'b000, 1'b1, 1'b0, 3'b000, "mid after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
